// File: rtl/mips_defs.sv
// mips_defs: shared encodings, hazard timing codes and decode record for the MIPS pipeline.
package mips_defs;
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] F_JR       = 6'h08;
  localparam logic [5:0] F_MFHI     = 6'h10;
  localparam logic [5:0] F_MTHI     = 6'h11;
  localparam logic [5:0] F_MFLO     = 6'h12;
  localparam logic [5:0] F_MTLO     = 6'h13;
  localparam logic [5:0] F_MULT     = 6'h18;
  localparam logic [5:0] F_MULTU    = 6'h19;
  localparam logic [5:0] F_DIV      = 6'h1a;
  localparam logic [5:0] F_DIVU     = 6'h1b;
  localparam logic [5:0] F_ADDU     = 6'h21;
  localparam logic [5:0] F_SUBU     = 6'h23;
  localparam logic [1:0] TUSE_0 = 2'd0;
  localparam logic [1:0] TUSE_1 = 2'd1;
  localparam logic [1:0] TUSE_2 = 2'd2;
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam logic [4:0] REG_RA = 5'd31;
  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] a3;
    logic [1:0] tnew_e;
    logic       is_md;
    logic       is_div;
    logic       is_mdop;
  } dec_t;
  function automatic logic stall_hit(logic use_src, logic [4:0] src, logic [1:0] tuse,
                                     logic [4:0] a3, logic [1:0] tnew);
    return use_src && a3 != 5'd0 && a3 == src && tuse < tnew;
  endfunction
endpackage

// File: rtl/instr_decode.sv
// instr_decode: classifies one instruction word into source use, destination and hazard timing.
module instr_decode
  import mips_defs::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);
  logic [5:0] op, fn;
  logic r, addu, subu, jr, mfhi, mflo, mthi, mtlo, mult, multu, div, divu;
  logic ori, lui, lw, sw, beq, jal, unused_ok;
  assign op    = ir[31:26];
  assign fn    = ir[5:0];
  assign r     = op == OP_SPECIAL;
  assign addu  = r && fn == F_ADDU;
  assign subu  = r && fn == F_SUBU;
  assign jr    = r && fn == F_JR;
  assign mfhi  = r && fn == F_MFHI;
  assign mflo  = r && fn == F_MFLO;
  assign mthi  = r && fn == F_MTHI;
  assign mtlo  = r && fn == F_MTLO;
  assign mult  = r && fn == F_MULT;
  assign multu = r && fn == F_MULTU;
  assign div   = r && fn == F_DIV;
  assign divu  = r && fn == F_DIVU;
  assign ori   = op == OP_ORI;
  assign lui   = op == OP_LUI;
  assign lw    = op == OP_LW;
  assign sw    = op == OP_SW;
  assign beq   = op == OP_BEQ;
  assign jal   = op == OP_JAL;
  assign unused_ok = ^ir[10:6];
  always_comb begin
    dec.is_md   = mult | multu | div | divu;
    dec.is_div  = div | divu;
    dec.is_mdop = dec.is_md | mfhi | mflo | mthi | mtlo;
    dec.uses_rs = addu | subu | ori | lw | sw | beq | jr | dec.is_md | mthi | mtlo;
    dec.uses_rt = addu | subu | sw | beq | dec.is_md;
    dec.tuse_rs = (beq | jr) ? TUSE_0 : TUSE_1;
    dec.tuse_rt = beq ? TUSE_0 : sw ? TUSE_2 : TUSE_1;
    dec.a3      = (addu | subu | mfhi | mflo) ? ir[15:11] :
                  (ori | lui | lw) ? ir[20:16] : jal ? REG_RA : 5'd0;
    dec.tnew_e  = lw ? TNEW_2 : (addu | subu | ori | lui | mfhi | mflo) ? TNEW_1 : TNEW_0;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tuse/Tnew stall detection and mult/div busy sequencing for the 5-stage pipeline.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        Stall,
  output logic        Flush_E,
  output logic        MD_Start,
  output logic        MD_Busy
);
  dec_t d, e, m;
  logic [3:0] cnt;
  logic [4:0] rs_d, rt_d;
  logic [1:0] tnew_m;
  logic data_stall, unused_ok;
  instr_decode u_dec_d (.ir(IR_D), .dec(d));
  instr_decode u_dec_e (.ir(IR_E), .dec(e));
  instr_decode u_dec_m (.ir(IR_M), .dec(m));
  assign rs_d   = IR_D[25:21];
  assign rt_d   = IR_D[20:16];
  // One stage further down the pipe, the producer is one cycle closer to its result.
  assign tnew_m = m.tnew_e != TNEW_0 ? m.tnew_e - 2'd1 : TNEW_0;
  assign unused_ok = ^{e, m};
  assign data_stall = stall_hit(d.uses_rs, rs_d, d.tuse_rs, e.a3, e.tnew_e)
                    | stall_hit(d.uses_rt, rt_d, d.tuse_rt, e.a3, e.tnew_e)
                    | stall_hit(d.uses_rs, rs_d, d.tuse_rs, m.a3, tnew_m)
                    | stall_hit(d.uses_rt, rt_d, d.tuse_rt, m.a3, tnew_m);
  assign MD_Start = e.is_md;
  assign MD_Busy  = cnt != 4'd0 || MD_Start;
  assign Stall    = data_stall | (d.is_mdop & MD_Busy);
  assign Flush_E  = Stall;
  always_ff @(posedge Clock) begin
    if (Reset) cnt <= 4'd0;
    else if (MD_Start) cnt <= e.is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench driving D/E/M instruction words and checking stall/MD outputs.
module tb_hazard_ctrl;
  logic Clock = 1'b0;
  logic Reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic Stall, Flush_E, MD_Start, MD_Busy;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  hazard_ctrl dut (
    .Clock(Clock), .Reset(Reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .Stall(Stall), .Flush_E(Flush_E), .MD_Start(MD_Start), .MD_Busy(MD_Busy)
  );
  always #5 Clock = ~Clock;
  function automatic logic [31:0] rt_i(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] it_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  task automatic check(string tag, logic [3:0] got, logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, got, exp);
    end
  endtask
  task automatic cyc(string tag, logic rst, logic [31:0] d, logic [31:0] e, logic [31:0] m,
                     logic [3:0] exp);
    Reset = rst;
    IR_D = d;
    IR_E = e;
    IR_M = m;
    sb.push_back(exp);
    @(negedge Clock);
    check(tag, {Stall, Flush_E, MD_Start, MD_Busy}, sb.pop_front());
    @(posedge Clock);
    #1;
  endtask
  initial begin
    logic [31:0] lw1, addu2, beq1, sw_rt1, sw_base1, addu1, ori0, addu3, mult12, div12, mflo3;
    logic [31:0] jal_i, jr31, mfhi1, addu_other, mthi1;
    lw1        = it_i(6'h23, 0, 1, 0);
    addu2      = rt_i(1, 1, 2, 6'h21);
    beq1       = it_i(6'h04, 1, 0, 4);
    sw_rt1     = it_i(6'h2b, 2, 1, 0);
    sw_base1   = it_i(6'h2b, 1, 2, 0);
    addu1      = rt_i(4, 5, 1, 6'h21);
    ori0       = it_i(6'h0d, 0, 0, 5);
    addu3      = rt_i(0, 0, 3, 6'h21);
    mult12     = rt_i(1, 2, 0, 6'h18);
    div12      = rt_i(1, 2, 0, 6'h1a);
    mflo3      = rt_i(0, 0, 3, 6'h12);
    jal_i      = {6'h03, 26'd16};
    jr31       = rt_i(31, 0, 0, 6'h08);
    mfhi1      = rt_i(0, 0, 1, 6'h10);
    addu_other = rt_i(3, 4, 2, 6'h21);
    mthi1      = rt_i(1, 0, 0, 6'h11);
    Reset = 1'b1;
    IR_D = '0;
    IR_E = '0;
    IR_M = '0;
    @(posedge Clock);
    #1;
    cyc("reset", 1'b1, '0, '0, '0, 4'b0000);
    cyc("idle", 1'b0, '0, '0, '0, 4'b0000);
    cyc("lw_e_addu", 1'b0, addu2, lw1, '0, 4'b1100);
    cyc("lw_m_addu", 1'b0, addu2, '0, lw1, 4'b0000);
    cyc("lw_e_beq", 1'b0, beq1, lw1, '0, 4'b1100);
    cyc("lw_m_beq", 1'b0, beq1, '0, lw1, 4'b1100);
    cyc("beq_free", 1'b0, beq1, '0, '0, 4'b0000);
    cyc("addu_e_sw_rt", 1'b0, sw_rt1, addu1, '0, 4'b0000);
    cyc("addu_e_sw_base", 1'b0, sw_base1, addu1, '0, 4'b0000);
    cyc("lw_e_sw_base", 1'b0, sw_base1, lw1, '0, 4'b1100);
    cyc("lw_e_sw_rt", 1'b0, sw_rt1, lw1, '0, 4'b0000);
    cyc("ori_r0", 1'b0, addu3, ori0, '0, 4'b0000);
    cyc("other_reg", 1'b0, addu_other, lw1, '0, 4'b0000);
    cyc("jal_jr", 1'b0, jr31, jal_i, '0, 4'b0000);
    cyc("mfhi_e_beq", 1'b0, beq1, mfhi1, '0, 4'b1100);
    cyc("md_in_m", 1'b0, mflo3, '0, mult12, 4'b0000);
    cyc("mult_start", 1'b0, mflo3, mult12, '0, 4'b1111);
    for (int i = 0; i < 5; i++) cyc("mult_busy", 1'b0, mflo3, '0, '0, 4'b1101);
    cyc("mult_done", 1'b0, mflo3, '0, '0, 4'b0000);
    cyc("mult_busy_nonmd", 1'b0, '0, mult12, '0, 4'b0011);
    cyc("busy_addu_free", 1'b0, addu3, '0, '0, 4'b0001);
    for (int i = 0; i < 4; i++) cyc("busy_mthi", 1'b0, mthi1, '0, '0, 4'b1101);
    cyc("mthi_free", 1'b0, mthi1, '0, '0, 4'b0000);
    cyc("div_start", 1'b0, mflo3, div12, '0, 4'b1111);
    for (int i = 0; i < 10; i++) cyc("div_busy", 1'b0, mflo3, '0, '0, 4'b1101);
    cyc("div_done", 1'b0, mflo3, '0, '0, 4'b0000);
    cyc("rst_div_start", 1'b0, mflo3, div12, '0, 4'b1111);
    cyc("rst_div_busy", 1'b0, mflo3, '0, '0, 4'b1101);
    cyc("rst_asserted", 1'b1, mflo3, '0, '0, 4'b1101);
    cyc("rst_cleared", 1'b0, mflo3, '0, '0, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
